// File: rtl/stopwatch_pkg.sv
// Shared state encodings for the mm:ss stopwatch controller.
package stopwatch_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PAUSE   = 3'd2,
        S_SET_SEC = 3'd3,
        S_SET_MIN = 3'd4
    } state_t;

endpackage

// File: rtl/count_60.sv
// Modulo-60 counter used for the seconds and minutes fields; rst is a synchronous clear.
module count_60 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [5:0] q,
    output logic       co
);

    assign co = en && (q == 6'd59);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= (q == 6'd59) ? '0 : q + 6'd1;
        end
    end

endmodule

// File: rtl/tick_prescaler.sv
// Divides clk down to the 1 s tick period; counts, holds or zeroes under control of the FSM.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int TICK_W   = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              hold,
    input  logic              clr,
    output logic [TICK_W-1:0] cnt,
    output logic              wrap
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + TICK_W'(1);
        end else if (!hold) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/set controller for a mm:ss stopwatch: owns the tick prescaler, counter enables and clear.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int TICK_W   = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               btn_clear,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               sec_co,
    input  logic               min_co,
    output logic               sec_en,
    output logic               min_en,
    output logic               cnt_rst,
    output logic [STATE_W-1:0] state,
    output logic               tick,
    output logic               blink,
    output logic               overflow
);

    localparam logic [TICK_W-1:0] HALF = TICK_W'(TICK_DIV / 2);

    state_t            state_q;
    logic              start_p;
    logic              mode_p;
    logic              inc_p;
    logic              pre_run;
    logic              pre_hold;
    logic              pre_clr;
    logic              pre_wrap;
    logic [TICK_W-1:0] pre_cnt;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (pre_run),
        .hold (pre_hold),
        .clr  (pre_clr),
        .cnt  (pre_cnt),
        .wrap (pre_wrap)
    );

    assign state = state_q;

    // Lower-priority pulses are masked so each cycle acts on at most one button.
    always_comb begin
        start_p  = btn_start & ~btn_clear;
        mode_p   = btn_mode & ~btn_clear & ~btn_start;
        inc_p    = btn_inc & ~btn_clear & ~btn_start & ~btn_mode;
        pre_run  = (state_q == S_RUN) || (state_q == S_SET_SEC) || (state_q == S_SET_MIN);
        pre_hold = (state_q == S_PAUSE);
        pre_clr  = btn_clear
                 | (start_p && (state_q == S_IDLE || state_q == S_SET_SEC || state_q == S_SET_MIN))
                 | (mode_p && (state_q == S_IDLE || state_q == S_PAUSE));
        tick     = (state_q == S_RUN) && pre_wrap;
        sec_en   = tick | ((state_q == S_SET_SEC) && inc_p);
        min_en   = ((state_q == S_RUN) && sec_co) | ((state_q == S_SET_MIN) && inc_p);
        blink    = 1'b1;
        if (state_q == S_SET_SEC || state_q == S_SET_MIN) begin
            blink = (pre_cnt >= HALF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_rst  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            cnt_rst <= btn_clear;
            if (btn_clear) begin
                state_q  <= S_IDLE;
                overflow <= 1'b0;
            end else begin
                if (state_q == S_RUN && min_co) begin
                    overflow <= 1'b1;
                end
                if (start_p) begin
                    state_q <= (state_q == S_RUN) ? S_PAUSE : S_RUN;
                end else if (mode_p) begin
                    case (state_q)
                        S_IDLE, S_PAUSE: state_q <= S_SET_SEC;
                        S_SET_SEC:       state_q <= S_SET_MIN;
                        S_SET_MIN:       state_q <= S_PAUSE;
                        default:         state_q <= state_q;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with two chained count_60 counters and a seconds/minutes reference model.
module tb_stopwatch_ctrl;

    localparam int DIV      = 4;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_SSEC  = 3;
    localparam int ST_SMIN  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sec_co, min_co, sec_en, min_en, cnt_rst, tick, blink, overflow;
    logic [2:0] state;
    logic [5:0] sec_q, min_q;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: plain numbers for time, prescaler and mode
    int m_state, m_p, m_s, m_m;
    bit m_ovf, m_crst;

    // values sampled at the last negedge
    int o_state, o_sec, o_min;
    bit o_tick, o_se, o_me, o_cr, o_bl, o_ovf;

    typedef struct {
        bit clr, start, mode, inc;
        int st;
        bit tk, se, me, cr, bl;
        int sec, mn;
    } vec_t;

    vec_t tbl[19];

    stopwatch_ctrl #(.TICK_DIV(DIV), .TICK_W(2)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .sec_co(sec_co), .min_co(min_co),
        .sec_en(sec_en), .min_en(min_en), .cnt_rst(cnt_rst), .state(state),
        .tick(tick), .blink(blink), .overflow(overflow)
    );

    count_60 u_sec (.clk(clk), .rst(cnt_rst), .en(sec_en), .q(sec_q), .co(sec_co));
    count_60 u_min (.clk(clk), .rst(cnt_rst), .en(min_en), .q(min_q), .co(min_co));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE;
        m_p = 0;
        m_s = 0;
        m_m = 0;
        m_ovf = 0;
        m_crst = 1;
    endtask

    task automatic apply_reset();
        {btn_clear, btn_start, btn_mode, btn_inc} = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive buttons, compare against the model at negedge, advance the model.
    task automatic step(input bit c, input bit s, input bit md, input bit i);
        bit st_p, md_p, in_p, e_tk, e_se, e_me, e_bl, ovf_set;
        int old;
        btn_clear = c;
        btn_start = s;
        btn_mode  = md;
        btn_inc   = i;
        st_p = s & ~c;
        md_p = md & ~c & ~s;
        in_p = i & ~c & ~s & ~md;
        e_tk = (m_state == ST_RUN) && (m_p == DIV - 1);
        e_se = e_tk || (m_state == ST_SSEC && in_p);
        e_me = (e_tk && m_s == 59) || (m_state == ST_SMIN && in_p);
        e_bl = (m_state == ST_SSEC || m_state == ST_SMIN) ? (m_p >= DIV / 2) : 1'b1;
        @(negedge clk);
        o_state = int'(state); o_sec = int'(sec_q); o_min = int'(min_q);
        o_tick = tick; o_se = sec_en; o_me = min_en; o_cr = cnt_rst; o_bl = blink; o_ovf = overflow;
        chk("state", o_state, m_state);
        chk("tick", o_tick, e_tk);
        chk("sec_en", o_se, e_se);
        chk("min_en", o_me, e_me);
        chk("cnt_rst", o_cr, m_crst);
        chk("blink", o_bl, e_bl);
        chk("overflow", o_ovf, m_ovf);
        chk("seconds", o_sec, m_s);
        chk("minutes", o_min, m_m);
        ovf_set = (m_state == ST_RUN) && e_me && (m_m == 59);
        if (m_crst) begin
            m_s = 0;
            m_m = 0;
        end else begin
            if (e_se) m_s = (m_s + 1) % 60;
            if (e_me) m_m = (m_m + 1) % 60;
        end
        old = m_state;
        if (c) begin
            m_state = ST_IDLE; m_p = 0; m_ovf = 0; m_crst = 1;
        end else begin
            m_crst = 0;
            if (ovf_set) m_ovf = 1;
            if (old == ST_RUN || old == ST_SSEC || old == ST_SMIN) m_p = (m_p + 1) % DIV;
            else if (old == ST_IDLE) m_p = 0;
            if (st_p) begin
                if (old == ST_RUN) m_state = ST_PAUSE;
                else begin
                    if (old != ST_PAUSE) m_p = 0;
                    m_state = ST_RUN;
                end
            end else if (md_p) begin
                if (old == ST_IDLE || old == ST_PAUSE) begin
                    m_state = ST_SSEC; m_p = 0;
                end else if (old == ST_SSEC) m_state = ST_SMIN;
                else if (old == ST_SMIN) m_state = ST_PAUSE;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        // {clr,start,mode,inc}, state, tick, sec_en, min_en, cnt_rst, blink, sec, min
        tbl[0]  = '{0,0,0,0, 0, 0,0,0,1,1, 0,0};
        tbl[1]  = '{0,1,0,0, 0, 0,0,0,0,1, 0,0};
        tbl[2]  = '{0,0,0,0, 1, 0,0,0,0,1, 0,0};
        tbl[3]  = '{0,0,0,0, 1, 0,0,0,0,1, 0,0};
        tbl[4]  = '{0,0,0,0, 1, 0,0,0,0,1, 0,0};
        tbl[5]  = '{0,0,0,0, 1, 1,1,0,0,1, 0,0};
        tbl[6]  = '{0,0,0,0, 1, 0,0,0,0,1, 1,0};
        tbl[7]  = '{0,1,0,0, 1, 0,0,0,0,1, 1,0};
        tbl[8]  = '{0,0,0,0, 2, 0,0,0,0,1, 1,0};
        tbl[9]  = '{0,0,1,0, 2, 0,0,0,0,1, 1,0};
        tbl[10] = '{0,0,0,1, 3, 0,1,0,0,0, 1,0};
        tbl[11] = '{0,0,0,0, 3, 0,0,0,0,0, 2,0};
        tbl[12] = '{0,0,0,0, 3, 0,0,0,0,1, 2,0};
        tbl[13] = '{0,0,1,0, 3, 0,0,0,0,1, 2,0};
        tbl[14] = '{0,0,0,1, 4, 0,0,1,0,0, 2,0};
        tbl[15] = '{0,0,1,1, 4, 0,0,0,0,0, 2,1};
        tbl[16] = '{1,1,0,0, 2, 0,0,0,0,1, 2,1};
        tbl[17] = '{0,0,0,0, 0, 0,0,0,1,1, 2,1};
        tbl[18] = '{0,0,0,0, 0, 0,0,0,0,1, 0,0};

        apply_reset();
        for (int k = 0; k < 19; k++) begin
            step(tbl[k].clr, tbl[k].start, tbl[k].mode, tbl[k].inc);
            chk("tbl_state", o_state, tbl[k].st);
            chk("tbl_tick", o_tick, tbl[k].tk);
            chk("tbl_sec_en", o_se, tbl[k].se);
            chk("tbl_min_en", o_me, tbl[k].me);
            chk("tbl_cnt_rst", o_cr, tbl[k].cr);
            chk("tbl_blink", o_bl, tbl[k].bl);
            chk("tbl_sec", o_sec, tbl[k].sec);
            chk("tbl_min", o_min, tbl[k].mn);
        end

        // run 00:00 -> 00:59, then the carry tick
        step(0, 1, 0, 0);
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            step(0, 0, 0, 0);
            if (o_tick && o_sec == 59) found = 1;
        end
        chk("wait_0059_done", found, 1);
        chk("carry_sec_en", o_se, 1);
        chk("carry_min_en", o_me, 1);
        step(0, 0, 0, 0);
        chk("carry_sec", o_sec, 0);
        chk("carry_min", o_min, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // set 59:59 by hand, checking both field wraps on the way
        step(0, 0, 1, 0);
        repeat (59) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("ssec_at59", o_sec, 59);
        chk("ssec_no_min_en", o_me, 0);
        repeat (59) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("ssec_wrap_min", o_min, 0);
        chk("ssec_sec59", o_sec, 59);
        repeat (59) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("smin_at59", o_min, 59);
        chk("smin_min_en", o_me, 1);
        step(0, 0, 0, 0);
        chk("smin_wrap", o_min, 0);
        chk("smin_wrap_no_ovf", o_ovf, 0);
        repeat (59) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("set_5959_min", o_min, 59);
        step(0, 1, 0, 0);
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            step(0, 0, 0, 0);
            if (o_tick) found = 1;
        end
        chk("wait_5959_tick", found, 1);
        chk("wrap_min_en", o_me, 1);
        step(0, 0, 0, 0);
        chk("wrap_sec", o_sec, 0);
        chk("wrap_min", o_min, 0);
        chk("wrap_overflow", o_ovf, 1);

        // pause at prescaler 2, idle 20 cycles, resume
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("pause_press_tick", o_tick, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0);
            chk("pause_no_tick", o_tick, 0);
            chk("pause_state", o_state, ST_PAUSE);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("resume_state", o_state, ST_RUN);
        chk("resume_tick", o_tick, 1);

        // clear beats start in the same cycle
        step(1, 1, 0, 0);
        chk("clr_start_state", o_state, ST_RUN);
        step(0, 0, 0, 0);
        chk("clr_state", o_state, ST_IDLE);
        chk("clr_cnt_rst", o_cr, 1);
        chk("clr_overflow", o_ovf, 0);
        step(0, 0, 0, 0);
        chk("clr_sec", o_sec, 0);
        chk("clr_min", o_min, 0);
        chk("clr_cnt_rst_1cyc", o_cr, 0);

        // asynchronous reset between edges while a tick is pending
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        #1;
        chk("pre_rst_tick", tick, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_state", state, ST_IDLE);
        chk("async_rst_tick", tick, 0);
        chk("async_rst_cnt_rst", cnt_rst, 1);
        apply_reset();

        // randomized buttons against the model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0);
        end

        {btn_clear, btn_start, btn_mode, btn_inc} = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
